multicycle_control_unit: RTL

Sequential successor to the hardwired opcode decoder. Drives the multicycle SimpleRISC datapath through FETCH/DECODE/EXEC/MEM/WB, with variable-latency support for iterative MUL/DIV/MOD and a request/acknowledge handshake to data memory. It sits between the instruction register, the flags register and the datapath strobes (PC, register file, ALU, memory).

---
 rtl/cu_pkg.sv | 79 +++++++
 rtl/cu_decoder.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types for the multicycle SimpleRISC controller: opcodes, FSM states,
// ALU operations and the decoder's instruction classes.
package cu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_MUL  = 5'b00010,
    OP_DIV  = 5'b00011,
    OP_MOD  = 5'b00100,
    OP_CMP  = 5'b00101,
    OP_AND  = 5'b00110,
    OP_OR   = 5'b00111,
    OP_NOT  = 5'b01000,
    OP_MOV  = 5'b01001,
    OP_LSL  = 5'b01010,
    OP_LSR  = 5'b01011,
    OP_ASR  = 5'b01100,
    OP_NOP  = 5'b01101,
    OP_LD   = 5'b01110,
    OP_ST   = 5'b01111,
    OP_BEQ  = 5'b10000,
    OP_BGT  = 5'b10001,
    OP_B    = 5'b10010,
    OP_CALL = 5'b10011,
    OP_RET  = 5'b10100
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MULDIV,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_DIV,
    ALU_MOD,
    ALU_CMP,
    ALU_AND,
    ALU_OR,
    ALU_NOT,
    ALU_MOV,
    ALU_LSL,
    ALU_LSR,
    ALU_ASR
  } alu_op_t;

  // CLS_JMP covers the unconditional transfers that do not write back (b, ret).
  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_MUL,
    CLS_DIV,
    CLS_CMP,
    CLS_NOP,
    CLS_LD,
    CLS_ST,
    CLS_BEQ,
    CLS_BGT,
    CLS_JMP,
    CLS_CALL
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    alu_op_t   aluSel;
    logic      illegal;
  } decode_t;

  function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: maps a 5-bit opcode to its instruction class,
// ALU operation and an illegal-opcode flag.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec.cls     = CLS_NOP;
    dec.aluSel  = ALU_ADD;
    dec.illegal = 1'b0;
    case (opcode)
      OP_ADD:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_ADD; end
      OP_SUB:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_SUB; end
      OP_MUL:  begin dec.cls = CLS_MUL;  dec.aluSel = ALU_MUL; end
      OP_DIV:  begin dec.cls = CLS_DIV;  dec.aluSel = ALU_DIV; end
      OP_MOD:  begin dec.cls = CLS_DIV;  dec.aluSel = ALU_MOD; end
      OP_CMP:  begin dec.cls = CLS_CMP;  dec.aluSel = ALU_CMP; end
      OP_AND:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_AND; end
      OP_OR:   begin dec.cls = CLS_ALU;  dec.aluSel = ALU_OR;  end
      OP_NOT:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_NOT; end
      OP_MOV:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_MOV; end
      OP_LSL:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_LSL; end
      OP_LSR:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_LSR; end
      OP_ASR:  begin dec.cls = CLS_ALU;  dec.aluSel = ALU_ASR; end
      OP_NOP:  dec.cls = CLS_NOP;
      OP_LD:   dec.cls = CLS_LD;
      OP_ST:   dec.cls = CLS_ST;
      OP_BEQ:  dec.cls = CLS_BEQ;
      OP_BGT:  dec.cls = CLS_BGT;
      OP_B:    dec.cls = CLS_JMP;
      OP_CALL: dec.cls = CLS_CALL;
      OP_RET:  dec.cls = CLS_JMP;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle SimpleRISC controller: FETCH/DECODE/EXEC/MULDIV/MEM/WB sequencer
// with an iterative MUL/DIV latency counter and a req/ack data-memory wait.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [4:0] opcode,
  input  logic       imm,
  input  logic       flag_eq,
  input  logic       flag_gt,
  input  logic       mem_ack,
  output logic       pc_inc,
  output logic       pc_branch,
  output logic       alu_start,
  output alu_op_t    alu_sel,
  output logic       is_imm,
  output logic       flags_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       rf_we,
  output logic       rf_ra_sel,
  output logic       illegal_op
);

  localparam int unsigned CNT_W = $clog2(maxU(MUL_CYCLES, DIV_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  op_class_t        cls;
  logic             illegalQ;
  logic             running;
  logic [CNT_W-1:0] cnt;
  decode_t          dec;
  logic             taken;
  logic             usesAlu;

  cu_decoder uDecoder (
    .opcode(opcode),
    .dec   (dec)
  );

  // running keeps instr_ready low while reset is held, raising it one cycle after release.
  assign instr_ready = running && (state == ST_FETCH);
  assign mem_req     = (state == ST_MEM);

  always_comb begin
    taken   = (cls == CLS_JMP) || (cls == CLS_CALL) ||
              ((cls == CLS_BEQ) && flag_eq) || ((cls == CLS_BGT) && flag_gt);
    usesAlu = (cls == CLS_ALU) || (cls == CLS_MUL) || (cls == CLS_DIV) ||
              (cls == CLS_CMP) || (cls == CLS_LD)  || (cls == CLS_ST);
  end

  // Strobes are set on the edge entering the state in which they must be seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      cls        <= CLS_NOP;
      illegalQ   <= 1'b0;
      running    <= 1'b0;
      cnt        <= '0;
      pc_inc     <= 1'b0;
      pc_branch  <= 1'b0;
      alu_start  <= 1'b0;
      alu_sel    <= ALU_ADD;
      is_imm     <= 1'b0;
      flags_we   <= 1'b0;
      mem_we     <= 1'b0;
      rf_we      <= 1'b0;
      rf_ra_sel  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      running    <= 1'b1;
      pc_inc     <= 1'b0;
      pc_branch  <= 1'b0;
      alu_start  <= 1'b0;
      flags_we   <= 1'b0;
      rf_we      <= 1'b0;
      rf_ra_sel  <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (running && instr_valid) begin
            state      <= ST_DECODE;
            cls        <= dec.cls;
            alu_sel    <= dec.aluSel;
            illegalQ   <= dec.illegal;
            is_imm     <= imm;
            illegal_op <= dec.illegal;
            pc_inc     <= !dec.illegal;
          end
        end
        ST_DECODE: begin
          if (illegalQ) begin
            state <= ST_FETCH;
          end else begin
            state     <= ST_EXEC;
            alu_start <= usesAlu;
            flags_we  <= (cls == CLS_CMP);
            pc_branch <= taken;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_MUL: begin
              cnt   <= MUL_LOAD;
              state <= ST_MULDIV;
            end
            CLS_DIV: begin
              cnt   <= DIV_LOAD;
              state <= ST_MULDIV;
            end
            CLS_LD: begin
              mem_we <= 1'b0;
              state  <= ST_MEM;
            end
            CLS_ST: begin
              mem_we <= 1'b1;
              state  <= ST_MEM;
            end
            CLS_ALU, CLS_CALL: begin
              rf_we     <= 1'b1;
              rf_ra_sel <= (cls == CLS_CALL);
              state     <= ST_WB;
            end
            default: state <= ST_FETCH;
          endcase
        end
        ST_MULDIV: begin
          if (cnt == '0) begin
            rf_we <= 1'b1;
            state <= ST_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (mem_we) begin
              state <= ST_FETCH;
            end else begin
              rf_we <= 1'b1;
              state <= ST_WB;
            end
          end
        end
        ST_WB: state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
